// File: rtl/fetch_thread_sched.sv
// rtl/fetch_thread_sched.sv - round-robin 4-thread PC generator feeding the IF/ID register
// Issues one active thread per enabled cycle; branch redirects bypass into the same-cycle fetch.
module fetch_thread_sched #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [3:0]      thread_active,
  input  logic            br_valid,
  input  logic [1:0]      br_tid,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] IF_pc,
  output logic [1:0]      IF_tid,
  output logic            IF_valid
);

  logic [PC_W-1:0] pc_q [4];
  logic [PC_W-1:0] pc_d [4];
  logic [1:0]      last_tid_q, last_tid_d;
  logic [PC_W-1:0] if_pc_q, if_pc_d;
  logic [1:0]      if_tid_q, if_tid_d;
  logic            if_valid_q, if_valid_d;

  logic [1:0]      sel;
  logic            sel_found;
  logic            issue;
  logic            br_hits_sel;
  logic [PC_W-1:0] addr;

  // Search starts just after the last issued thread and ends on it, so a lone
  // active thread is picked every cycle.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!sel_found && thread_active[last_tid_q + 2'(k)]) begin
        sel       = last_tid_q + 2'(k);
        sel_found = 1'b1;
      end
    end
  end

  assign issue       = en && sel_found;
  assign br_hits_sel = br_valid && (br_tid == sel);
  assign addr        = br_hits_sel ? br_target : pc_q[sel];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pc_d[i] = pc_q[i];
      if (issue && (sel == 2'(i))) begin
        pc_d[i] = addr + PC_W'(1);
      end else if (br_valid && (br_tid == 2'(i))) begin
        // Non-issued redirect lands even while stalled or inactive.
        pc_d[i] = br_target;
      end
    end
  end

  always_comb begin
    last_tid_d = last_tid_q;
    if_pc_d    = if_pc_q;
    if_tid_d   = if_tid_q;
    if_valid_d = if_valid_q;
    if (en) begin
      if (sel_found) begin
        last_tid_d = sel;
        if_pc_d    = addr;
        if_tid_d   = sel;
        if_valid_d = 1'b1;
      end else begin
        if_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pc_q[i] <= RESET_PC;
      end
      last_tid_q <= 2'd3;
      if_pc_q    <= RESET_PC;
      if_tid_q   <= 2'd0;
      if_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pc_q[i] <= pc_d[i];
      end
      last_tid_q <= last_tid_d;
      if_pc_q    <= if_pc_d;
      if_tid_q   <= if_tid_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign IF_pc    = if_pc_q;
  assign IF_tid   = if_tid_q;
  assign IF_valid = if_valid_q;

endmodule

// File: tb/tb_fetch_thread_sched.sv
// tb/tb_fetch_thread_sched.sv - directed and randomized checks of fetch_thread_sched
// Expected outputs come from a per-thread PC array and round-robin search model.
module tb_fetch_thread_sched;

  localparam int PC_W = 10;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic [3:0]      thread_active;
  logic            br_valid;
  logic [1:0]      br_tid;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] IF_pc;
  logic [1:0]      IF_tid;
  logic            IF_valid;

  fetch_thread_sched #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .thread_active (thread_active),
    .br_valid      (br_valid),
    .br_tid        (br_tid),
    .br_target     (br_target),
    .IF_pc         (IF_pc),
    .IF_tid        (IF_tid),
    .IF_valid      (IF_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [PC_W-1:0] m_pc [4];
  int              m_last;
  logic [PC_W-1:0] m_if_pc;
  int              m_if_tid;
  logic            m_if_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pc[i] = '0;
    m_last     = 3;
    m_if_pc    = '0;
    m_if_tid   = 0;
    m_if_valid = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},    32'(IF_pc),    32'(m_if_pc));
    chk({tag, ".tid"},   32'(IF_tid),   32'(m_if_tid));
    chk({tag, ".valid"}, 32'(IF_valid), 32'(m_if_valid));
  endtask

  // Apply inputs for one cycle, advance the model by the spec's rules, compare after the edge.
  task automatic step(input logic e, input logic [3:0] m, input logic bv,
                      input logic [1:0] bt, input logic [PC_W-1:0] btg, input string tag);
    int              s;
    logic            issued;
    logic [PC_W-1:0] a;
    en = e; thread_active = m; br_valid = bv; br_tid = bt; br_target = btg;
    s = -1;
    for (int k = 1; k <= 4; k++) begin
      if (s < 0 && m[(m_last + k) % 4]) s = (m_last + k) % 4;
    end
    issued = e && (s >= 0);
    if (issued) begin
      a          = (bv && int'(bt) == s) ? btg : m_pc[s];
      m_if_pc    = a;
      m_if_tid   = s;
      m_if_valid = 1'b1;
      m_pc[s]    = PC_W'(a + 1);
      m_last     = s;
    end else if (e) begin
      m_if_valid = 1'b0;
    end
    if (bv && !(issued && int'(bt) == s)) m_pc[bt] = btg;
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_pc"},    32'(IF_pc),    32'd0);
    chk({tag, ".rst_tid"},   32'(IF_tid),   32'd0);
    chk({tag, ".rst_valid"}, 32'(IF_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; thread_active = '0;
    br_valid = 1'b0; br_tid = '0; br_target = '0;
    model_reset();
    #2;
    chk("reset.pc",    32'(IF_pc),    32'd0);
    chk("reset.tid",   32'(IF_tid),   32'd0);
    chk("reset.valid", 32'(IF_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four threads round-robin from reset.
    for (int i = 0; i < 8; i++) begin
      step(1, 4'b1111, 0, 0, 0, "rr4");
      chk("rr4.tid_c", 32'(IF_tid),   32'(i % 4));
      chk("rr4.pc_c",  32'(IF_pc),    32'(i / 4));
      chk("rr4.v_c",   32'(IF_valid), 32'd1);
    end

    // Sparse mask, then a single active thread.
    async_reset("m0101");
    for (int i = 0; i < 4; i++) begin
      step(1, 4'b0101, 0, 0, 0, "m0101");
      chk("m0101.tid_c", 32'(IF_tid), 32'((i % 2) * 2));
      chk("m0101.pc_c",  32'(IF_pc),  32'(i / 2));
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 4'b0100, 0, 0, 0, "m0100");
      chk("m0100.tid_c", 32'(IF_tid), 32'd2);
      chk("m0100.pc_c",  32'(IF_pc),  32'(2 + i));
    end

    // Same-cycle redirect bypass to the selected thread.
    async_reset("byp");
    step(1, 4'b1111, 0, 0, 0, "byp0");
    step(1, 4'b1111, 1, 2'd1, 10'h200, "byp1");
    chk("byp.pc_c",  32'(IF_pc),  32'h200);
    chk("byp.tid_c", 32'(IF_tid), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 4'b1111, 0, 0, 0, "byp_rr");
    step(1, 4'b1111, 0, 0, 0, "byp_next");
    chk("byp.next_tid_c", 32'(IF_tid), 32'd1);
    chk("byp.next_pc_c",  32'(IF_pc),  32'h201);

    // Redirect during a stall, then PC wrap at the top of the address space.
    async_reset("stall");
    for (int i = 0; i < 3; i++) step(1, 4'b1111, 0, 0, 0, "stall_pre");
    step(0, 4'b1111, 1, 2'd3, 10'h3FF, "stall0");
    chk("stall.frozen_tid", 32'(IF_tid), 32'd2);
    step(0, 4'b1111, 0, 0, 0, "stall1");
    step(0, 4'b1111, 0, 0, 0, "stall2");
    chk("stall.frozen_valid", 32'(IF_valid), 32'd1);
    step(1, 4'b1111, 0, 0, 0, "stall_t3");
    chk("stall.t3_tid", 32'(IF_tid), 32'd3);
    chk("stall.t3_pc",  32'(IF_pc),  32'h3FF);
    for (int i = 0; i < 3; i++) step(1, 4'b1111, 0, 0, 0, "stall_rr");
    step(1, 4'b1111, 0, 0, 0, "wrap");
    chk("wrap.tid", 32'(IF_tid), 32'd3);
    chk("wrap.pc",  32'(IF_pc),  32'h000);

    // Empty mask bubbles while holding pc/tid, then resumes after last_tid.
    step(1, 4'b0000, 0, 0, 0, "idle");
    chk("idle.valid_c", 32'(IF_valid), 32'd0);
    chk("idle.tid_c",   32'(IF_tid),   32'd3);
    step(1, 4'b0000, 0, 0, 0, "idle2");
    step(1, 4'b1111, 0, 0, 0, "resume");
    chk("resume.tid_c", 32'(IF_tid), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 4) != 0), 4'($urandom), ($urandom_range(0, 2) == 0),
           2'($urandom), PC_W'($urandom), "rand");
      if (i == 200) begin
        #2;
        async_reset("midrun");
      end
    end

    // Restart sequence after a mid-run reset.
    async_reset("final");
    step(1, 4'b1111, 0, 0, 0, "restart");
    chk("restart.tid_c", 32'(IF_tid), 32'd0);
    chk("restart.pc_c",  32'(IF_pc),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
